// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the instruction fetch stage:
// state encoding, halt opcode marker and the default datapath width.
package instr_fetch_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [7:0] HALT_OPCODE_HI = 8'hFF;
    localparam logic [3:0] ROM_OP_NIBBLE  = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register: jump load has priority over increment,
// increment wraps modulo 2^DATA_WIDTH.
module fetch_pc_counter #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_addr_i,
    output logic [DATA_WIDTH-1:0] pc_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM read, instruction register and valid/ready
// handoff. FETCH_BOUND_CHECK_EN enables the PC range fault.
//
// state    | meaning
// ST_IDLE  | waiting for run, ROM disabled
// ST_FETCH | ROM enabled at PC, IR captured on the next edge
// ST_HOLD  | instruction valid, waiting for accept or jump
// ST_HALT  | halt consumed (or fault); only reset leaves
module instr_fetch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    PROG_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic [DATA_WIDTH-1:0] rom_addr,
    output logic                  rom_enable,
    input  logic [DATA_WIDTH-1:0] rom_opcode,
    input  logic [DATA_WIDTH-1:0] rom_operand,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_operand,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  jump_valid,
    input  logic [DATA_WIDTH-1:0] jump_addr,
    output logic                  halted,
    output logic                  fault
);

    import instr_fetch_pkg::*;

    localparam logic [DATA_WIDTH-1:0] PC_LIMIT = PROG_DEPTH[DATA_WIDTH-1:0];

    fetch_state_t          state_q;
    logic                  rom_enable_q;
    logic                  valid_q;
    logic                  halted_q;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic [DATA_WIDTH-1:0] ipc_q;
    logic [DATA_WIDTH-1:0] pc;
    logic                  accept;
    logic                  halt_accept;
    logic                  pc_oob;
    logic                  pc_load;
    logic                  pc_inc;

    assign accept      = valid_q & instr_ready;
    assign halt_accept = accept & (opcode_q[DATA_WIDTH-1 -: 8] == HALT_OPCODE_HI);

`ifdef FETCH_BOUND_CHECK_EN
    logic fault_q;
    assign pc_oob = (pc >= PC_LIMIT);
    assign fault  = fault_q;
`else
    logic pc_limit_unused;
    assign pc_limit_unused = (pc >= PC_LIMIT);
    assign pc_oob          = 1'b0;
    assign fault           = 1'b0;
`endif

    // A halt accept wins over a same-cycle jump.
    assign pc_load = jump_valid & ((state_q == ST_FETCH) | ((state_q == ST_HOLD) & ~halt_accept));
    assign pc_inc  = (state_q == ST_FETCH) & ~jump_valid & ~pc_oob;

    fetch_pc_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (pc_inc),
        .load_i      (pc_load),
        .load_addr_i (jump_addr),
        .pc_o        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rom_enable_q <= 1'b0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            opcode_q     <= '0;
            operand_q    <= '0;
            ipc_q        <= '0;
`ifdef FETCH_BOUND_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q      <= ST_FETCH;
                        rom_enable_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (jump_valid) begin
                        state_q <= ST_FETCH;
                    end else if (pc_oob) begin
                        state_q      <= ST_HALT;
                        rom_enable_q <= 1'b0;
                        halted_q     <= 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
                        fault_q      <= 1'b1;
`endif
                    end else begin
                        state_q      <= ST_HOLD;
                        rom_enable_q <= 1'b0;
                        valid_q      <= 1'b1;
                        opcode_q     <= rom_opcode;
                        operand_q    <= rom_operand;
                        ipc_q        <= pc;
                    end
                end
                ST_HOLD: begin
                    if (halt_accept) begin
                        state_q  <= ST_HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (jump_valid) begin
                        state_q      <= ST_FETCH;
                        valid_q      <= 1'b0;
                        rom_enable_q <= 1'b1;
                    end else if (accept) begin
                        valid_q <= 1'b0;
                        if (run) begin
                            state_q      <= ST_FETCH;
                            rom_enable_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign rom_addr      = pc;
    assign rom_enable    = rom_enable_q;
    assign instr_valid   = valid_q;
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_pc      = ipc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small behavioural ROM.
module tb_instr_fetch;

    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] rom_addr;
    logic        rom_enable;
    logic [15:0] rom_opcode;
    logic [15:0] rom_operand;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_addr = '0;
    logic        halted;
    logic        fault;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .DATA_WIDTH (16),
        .PROG_DEPTH (16),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .rom_addr      (rom_addr),
        .rom_enable    (rom_enable),
        .rom_opcode    (rom_opcode),
        .rom_operand   (rom_operand),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .jump_valid    (jump_valid),
        .jump_addr     (jump_addr),
        .halted        (halted),
        .fault         (fault)
    );

    function automatic logic [15:0] rom_hi(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h3100;
            16'd1:   return 16'h3101;
            16'd2:   return {HALT_OPCODE_HI, 8'h00};
            16'd7:   return 16'h3107;
            default: return {ROM_OP_NIBBLE, 4'h0, a[7:0]};
        endcase
    endfunction

    function automatic logic [15:0] rom_lo(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h00AA;
            16'd1:   return 16'h00BB;
            16'd2:   return 16'h0000;
            16'd7:   return 16'h0077;
            default: return a;
        endcase
    endfunction

    always_comb begin
        rom_opcode  = rom_hi(rom_addr);
        rom_operand = rom_lo(rom_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({rom_addr, rom_enable, instr_valid, halted, fault} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got addr=%h en=%b v=%b h=%b f=%b want 0000 0 0 0 0",
                     rom_addr, rom_enable, instr_valid, halted, fault);
        end
        vectors++;
        if ({instr_opcode, instr_operand, instr_pc} !== 48'h0) begin
            errors++;
            $display("FAIL reset_ir: got %h %h %h want 0000 0000 0000", instr_opcode, instr_operand, instr_pc);
        end
        step();
        vectors++;
        if (rom_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_run: got en=%b want 0", rom_enable);
        end
    endtask

    task automatic test_fetch();
        run = 1'b1; instr_ready = 1'b1;
        step();
        vectors++;
        if ({rom_addr, rom_enable, instr_valid} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_c1: got addr=%h en=%b v=%b want 0000 1 0", rom_addr, rom_enable, instr_valid);
        end
        step();
        vectors++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc, rom_enable} !==
            {1'b1, 16'h3100, 16'h00AA, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL fetch_c2: got v=%b op=%h arg=%h pc=%h en=%b want 1 3100 00aa 0000 0",
                     instr_valid, instr_opcode, instr_operand, instr_pc, rom_enable);
        end
        step();
        vectors++;
        if ({rom_addr, rom_enable, instr_valid} !== {16'h0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_c3: got addr=%h en=%b v=%b want 0001 1 0", rom_addr, rom_enable, instr_valid);
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({instr_valid, instr_opcode, instr_operand, rom_addr, rom_enable} !==
                {1'b1, 16'h3101, 16'h00BB, 16'h0002, 1'b0}) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b op=%h arg=%h addr=%h en=%b want 1 3101 00bb 0002 0",
                         i, instr_valid, instr_opcode, instr_operand, rom_addr, rom_enable);
            end
            step();
        end
    endtask

    task automatic test_jump();
        jump_valid = 1'b1; jump_addr = 16'h0007; instr_ready = 1'b1;
        step();
        jump_valid = 1'b0; instr_ready = 1'b0;
        vectors++;
        if ({rom_addr, rom_enable, instr_valid} !== {16'h0007, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL jump_fetch: got addr=%h en=%b v=%b want 0007 1 0", rom_addr, rom_enable, instr_valid);
        end
        step();
        vectors++;
        if ({instr_valid, instr_pc, instr_opcode, instr_operand} !== {1'b1, 16'h0007, 16'h3107, 16'h0077}) begin
            errors++;
            $display("FAIL jump_hold: got v=%b pc=%h op=%h arg=%h want 1 0007 3107 0077",
                     instr_valid, instr_pc, instr_opcode, instr_operand);
        end
    endtask

    task automatic test_idle();
        run = 1'b0; instr_ready = 1'b1;
        step();
        vectors++;
        if ({instr_valid, rom_enable, rom_addr} !== {1'b0, 1'b0, 16'h0008}) begin
            errors++;
            $display("FAIL accept_idle: got v=%b en=%b addr=%h want 0 0 0008", instr_valid, rom_enable, rom_addr);
        end
        jump_valid = 1'b1; jump_addr = 16'h0002;
        step();
        step();
        jump_valid = 1'b0;
        vectors++;
        if ({rom_enable, rom_addr} !== {1'b0, 16'h0008}) begin
            errors++;
            $display("FAIL idle_jump_ignored: got en=%b addr=%h want 0 0008", rom_enable, rom_addr);
        end
    endtask

    task automatic test_halt();
        run = 1'b1;
        step();
        jump_valid = 1'b1; jump_addr = 16'h0002;
        step();
        jump_valid = 1'b0;
        vectors++;
        if ({rom_addr, rom_enable} !== {16'h0002, 1'b1}) begin
            errors++;
            $display("FAIL fetch_jump: got addr=%h en=%b want 0002 1", rom_addr, rom_enable);
        end
        step();
        vectors++;
        if ({instr_valid, instr_opcode, instr_pc} !== {1'b1, 16'hFF00, 16'h0002}) begin
            errors++;
            $display("FAIL halt_hold: got v=%b op=%h pc=%h want 1 ff00 0002", instr_valid, instr_opcode, instr_pc);
        end
        jump_valid = 1'b1; jump_addr = 16'h0009;
        step();
        jump_valid = 1'b0;
        vectors++;
        if ({halted, instr_valid, rom_enable, rom_addr} !== {1'b1, 1'b0, 1'b0, 16'h0003}) begin
            errors++;
            $display("FAIL halt_enter: got h=%b v=%b en=%b addr=%h want 1 0 0 0003",
                     halted, instr_valid, rom_enable, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            run = 1'b1; jump_valid = 1'b1; jump_addr = 16'h0001;
            step();
            run = 1'b0; jump_valid = 1'b0;
            step();
            vectors++;
            if ({halted, rom_enable, instr_valid, rom_addr} !== {1'b1, 1'b0, 1'b0, 16'h0003}) begin
                errors++;
                $display("FAIL halt_stuck_%0d: got h=%b en=%b v=%b addr=%h want 1 0 0 0003",
                         i, halted, rom_enable, instr_valid, rom_addr);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: got h=%b want 0", halted);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_range();
        run = 1'b1; instr_ready = 1'b0;
        step();
`ifdef FETCH_BOUND_CHECK_EN
        jump_valid = 1'b1; jump_addr = 16'h0010;
        step();
        jump_valid = 1'b0;
        step();
        vectors++;
        if ({fault, halted, instr_valid, rom_enable} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bound_fault: got f=%b h=%b v=%b en=%b want 1 1 0 0",
                     fault, halted, instr_valid, rom_enable);
        end
        step();
        vectors++;
        if ({fault, instr_valid} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bound_sticky: got f=%b v=%b want 1 0", fault, instr_valid);
        end
`else
        jump_valid = 1'b1; jump_addr = 16'hFFFF;
        step();
        jump_valid = 1'b0;
        vectors++;
        if ({rom_addr, rom_enable} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL wrap_fetch: got addr=%h en=%b want ffff 1", rom_addr, rom_enable);
        end
        step();
        instr_ready = 1'b1;
        vectors++;
        if ({instr_valid, instr_pc, instr_opcode, rom_addr, fault} !== {1'b1, 16'hFFFF, 16'h30FF, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL wrap_hold: got v=%b pc=%h op=%h addr=%h f=%b want 1 ffff 30ff 0000 0",
                     instr_valid, instr_pc, instr_opcode, rom_addr, fault);
        end
        step();
        vectors++;
        if ({rom_addr, rom_enable} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_next: got addr=%h en=%b want 0000 1", rom_addr, rom_enable);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1; instr_ready = 1'b0; jump_valid = 1'b1; jump_addr = 16'h0000;
        step();
        jump_valid = 1'b1; jump_addr = 16'h0005;
        step();
        jump_valid = 1'b0;
        step();
        vectors++;
        if ({instr_valid, instr_pc, rom_addr} !== {1'b1, 16'h0005, 16'h0006}) begin
            errors++;
            $display("FAIL pre_reset_hold: got v=%b pc=%h addr=%h want 1 0005 0006", instr_valid, instr_pc, rom_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({instr_valid, rom_enable, rom_addr, instr_opcode} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: got v=%b en=%b addr=%h op=%h want 0 0 0000 0000",
                     instr_valid, rom_enable, rom_addr, instr_opcode);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_jump();
        test_idle();
        test_halt();
        test_range();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
